// File: rtl/rtc_set_parser.sv
// Parses the UART time-set command "T" + YYMMDDhhmmssw + CR/LF into DS1302-ready BCD
// fields and holds a write request until the RTC write controller acknowledges it.
module rtc_set_parser #(
    parameter int CLK_HZ     = 100000000,
    parameter int TIMEOUT_MS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxDone,
    input  logic [7:0] rxData,
    input  logic       wrAck,
    output logic       wrReq,
    output logic [7:0] setSec,
    output logic [7:0] setMin,
    output logic [7:0] setHrs,
    output logic [7:0] setDate,
    output logic [7:0] setMon,
    output logic [7:0] setDay,
    output logic [7:0] setYr,
    output logic       busy,
    output logic       errPulse,
    output logic [2:0] errCode
);

    localparam int TIMEOUT_CYCLES = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int CW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CHAR_T  = 8'h54;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [3:0] LAST_DIGIT = 4'd12;

    localparam logic [2:0] ERR_BAD_CHAR = 3'd1;
    localparam logic [2:0] ERR_RANGE    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_NO_TERM  = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WAIT_TERM,
        CHECK,
        REQ
    } stateT;

    stateT         state;
    stateT         nextState;
    logic [3:0]    digitIdx;
    logic [CW-1:0] timeCount;
    logic [3:0]    digits [13];

    logic          isDigit;
    logic          isTerm;
    logic          timedOut;
    logic          counting;
    logic          storeDigit;
    logic          raiseErr;
    logic [2:0]    newErrCode;
    logic          loadSet;
    logic          fieldsValid;
    logic [6:0]    monVal;
    logic [6:0]    dateVal;
    logic [6:0]    hrsVal;
    logic [6:0]    minVal;
    logic [6:0]    secVal;

    function automatic logic [6:0] bcdValue(input logic [3:0] tens, input logic [3:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

    assign isDigit  = (rxData >= 8'h30) && (rxData <= 8'h39);
    assign isTerm   = (rxData == CHAR_CR) || (rxData == CHAR_LF);
    assign counting = (state == COLLECT) || (state == WAIT_TERM);
    assign timedOut = (timeCount == LAST_COUNT);
    assign busy     = (state != IDLE);

    // Digit order in the buffer: Y Y M M D D h h m m s s w; the year needs no check.
    assign monVal  = bcdValue(digits[2], digits[3]);
    assign dateVal = bcdValue(digits[4], digits[5]);
    assign hrsVal  = bcdValue(digits[6], digits[7]);
    assign minVal  = bcdValue(digits[8], digits[9]);
    assign secVal  = bcdValue(digits[10], digits[11]);

    assign fieldsValid = (monVal >= 7'd1) && (monVal <= 7'd12)
                      && (dateVal >= 7'd1) && (dateVal <= 7'd31)
                      && (hrsVal <= 7'd23)
                      && (minVal <= 7'd59)
                      && (secVal <= 7'd59)
                      && (digits[12] >= 4'd1) && (digits[12] <= 4'd7);

    // Next-state and control decode; a received byte always takes priority over timeout.
    always_comb begin
        nextState  = state;
        storeDigit = 1'b0;
        raiseErr   = 1'b0;
        newErrCode = 3'd0;
        loadSet    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rxDone && (rxData == CHAR_T)) begin
                    nextState = COLLECT;
                end
            end
            COLLECT: begin
                if (rxDone) begin
                    if (isDigit) begin
                        storeDigit = 1'b1;
                        if (digitIdx == LAST_DIGIT) begin
                            nextState = WAIT_TERM;
                        end
                    end else begin
                        raiseErr   = 1'b1;
                        newErrCode = ERR_BAD_CHAR;
                        nextState  = IDLE;
                    end
                end else if (timedOut) begin
                    raiseErr   = 1'b1;
                    newErrCode = ERR_TIMEOUT;
                    nextState  = IDLE;
                end
            end
            WAIT_TERM: begin
                if (rxDone) begin
                    if (isTerm) begin
                        nextState = CHECK;
                    end else begin
                        raiseErr   = 1'b1;
                        newErrCode = ERR_NO_TERM;
                        nextState  = IDLE;
                    end
                end else if (timedOut) begin
                    raiseErr   = 1'b1;
                    newErrCode = ERR_TIMEOUT;
                    nextState  = IDLE;
                end
            end
            CHECK: begin
                if (fieldsValid) begin
                    loadSet   = 1'b1;
                    nextState = REQ;
                end else begin
                    raiseErr   = 1'b1;
                    newErrCode = ERR_RANGE;
                    nextState  = IDLE;
                end
            end
            REQ: begin
                if (wrAck) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State, counters, error reporting and the held request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            digitIdx  <= 4'd0;
            timeCount <= '0;
            wrReq     <= 1'b0;
            errPulse  <= 1'b0;
            errCode   <= 3'd0;
            setSec    <= 8'h00;
            setMin    <= 8'h00;
            setHrs    <= 8'h00;
            setDate   <= 8'h00;
            setMon    <= 8'h00;
            setDay    <= 8'h00;
            setYr     <= 8'h00;
        end else begin
            state    <= nextState;
            errPulse <= raiseErr;
            if (raiseErr) begin
                errCode <= newErrCode;
            end

            if (state == IDLE) begin
                digitIdx <= 4'd0;
            end else if (storeDigit) begin
                digitIdx <= digitIdx + 4'd1;
            end

            if (counting && !rxDone && (nextState == state)) begin
                timeCount <= timeCount + 1'b1;
            end else begin
                timeCount <= '0;
            end

            if (loadSet) begin
                wrReq   <= 1'b1;
                setYr   <= {digits[0], digits[1]};
                setMon  <= {digits[2], digits[3]};
                setDate <= {digits[4], digits[5]};
                setHrs  <= {digits[6], digits[7]};
                setMin  <= {digits[8], digits[9]};
                setSec  <= {digits[10], digits[11]};
                setDay  <= {4'h0, digits[12]};
            end else if ((state == REQ) && wrAck) begin
                wrReq <= 1'b0;
            end
        end
    end

    // The digit buffer is only read after all 13 positions were written, so it needs no reset.
    always_ff @(posedge clk) begin
        if (storeDigit && (digitIdx <= LAST_DIGIT)) begin
            digits[digitIdx] <= rxData[3:0];
        end
    end

endmodule

// File: tb/tb_rtc_set_parser.sv
// Self-checking bench for rtc_set_parser: directed scenarios plus randomized commands
// predicted by a command-level model of the time-set protocol.
module tb_rtc_set_parser;

    localparam int CLK_HZ     = 1000000;
    localparam int TIMEOUT_MS = 1;
    localparam int LIMIT      = CLK_HZ / 1000 * TIMEOUT_MS;

    localparam int K_OK      = 0;
    localparam int K_BAD     = 1;
    localparam int K_RANGE   = 2;
    localparam int K_TIMEOUT = 3;
    localparam int K_NOTERM  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxDone;
    logic [7:0] rxData;
    logic       wrAck;
    logic       wrReq;
    logic [7:0] setSec, setMin, setHrs, setDate, setMon, setDay, setYr;
    logic       busy;
    logic       errPulse;
    logic [2:0] errCode;

    int         checks = 0;
    int         failures = 0;
    logic [2:0] expErrCode;
    logic [7:0] expSet [7];
    logic [7:0] predSet [7];
    int         expKind;
    int         expLast;
    logic [7:0] cmdQ [$];
    int         gapQ [$];
    logic [7:0] junkQ [$];

    rtc_set_parser #(.CLK_HZ(CLK_HZ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
        .clk(clk), .rst(rst), .rxDone(rxDone), .rxData(rxData), .wrAck(wrAck),
        .wrReq(wrReq), .setSec(setSec), .setMin(setMin), .setHrs(setHrs),
        .setDate(setDate), .setMon(setMon), .setDay(setDay), .setYr(setYr),
        .busy(busy), .errPulse(errPulse), .errCode(errCode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // expSet order: yr, mon, date, hrs, min, sec, day
    task automatic checkFields(input string tag);
        checkOutput({tag, " setYr"},   setYr,   expSet[0]);
        checkOutput({tag, " setMon"},  setMon,  expSet[1]);
        checkOutput({tag, " setDate"}, setDate, expSet[2]);
        checkOutput({tag, " setHrs"},  setHrs,  expSet[3]);
        checkOutput({tag, " setMin"},  setMin,  expSet[4]);
        checkOutput({tag, " setSec"},  setSec,  expSet[5]);
        checkOutput({tag, " setDay"},  setDay,  expSet[6]);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxDone = 1'b1;
        rxData = b;
        tick();
        rxDone = 1'b0;
        rxData = 8'($urandom);
    endtask

    task automatic checkResetState(input string tag);
        for (int k = 0; k < 7; k++) expSet[k] = 8'h00;
        expErrCode = 3'd0;
        checkOutput({tag, " wrReq"}, wrReq, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " errPulse"}, errPulse, 0);
        checkOutput({tag, " errCode"}, errCode, 0);
        checkFields(tag);
    endtask

    task automatic pulseReset(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResetState(tag);
    endtask

    task automatic ackRequest();
        wrAck = 1'b1;
        tick();
        wrAck = 1'b0;
        checkOutput("wrReq after ack", wrReq, 0);
        checkOutput("busy after ack", busy, 0);
    endtask

    function automatic int toBcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    // Command-level reference: decide where and how the command ends from the protocol rules.
    task automatic predictCommand();
        int d [13];
        int yr, mon, date, hrs, mins, sec, w;
        expKind = K_OK;
        expLast = 14;
        for (int i = 0; i <= 14; i++) begin
            if (i >= 1 && i <= 13 && (cmdQ[i] < 8'h30 || cmdQ[i] > 8'h39)) begin
                expKind = K_BAD;
                expLast = i;
                return;
            end
            if (i == 14 && cmdQ[i] != 8'h0D && cmdQ[i] != 8'h0A) begin
                expKind = K_NOTERM;
                expLast = i;
                return;
            end
            if (i < 14 && gapQ[i] >= LIMIT) begin
                expKind = K_TIMEOUT;
                expLast = i;
                return;
            end
        end
        for (int k = 0; k < 13; k++) d[k] = int'(cmdQ[k + 1]) - 48;
        yr   = d[0] * 10 + d[1];
        mon  = d[2] * 10 + d[3];
        date = d[4] * 10 + d[5];
        hrs  = d[6] * 10 + d[7];
        mins = d[8] * 10 + d[9];
        sec  = d[10] * 10 + d[11];
        w    = d[12];
        predSet[0] = 8'(toBcd(yr));
        predSet[1] = 8'(toBcd(mon));
        predSet[2] = 8'(toBcd(date));
        predSet[3] = 8'(toBcd(hrs));
        predSet[4] = 8'(toBcd(mins));
        predSet[5] = 8'(toBcd(sec));
        predSet[6] = 8'(w);
        if (!(mon >= 1 && mon <= 12 && date >= 1 && date <= 31 && hrs <= 23 &&
              mins <= 59 && sec <= 59 && w >= 1 && w <= 7)) begin
            expKind = K_RANGE;
        end
    endtask

    task automatic loadCmd(input string s, input bit addTerm, input logic [7:0] term);
        cmdQ.delete();
        gapQ.delete();
        junkQ.delete();
        for (int i = 0; i < s.len(); i++) cmdQ.push_back(s[i]);
        if (addTerm) cmdQ.push_back(term);
        for (int i = 0; i < 15; i++) gapQ.push_back(0);
    endtask

    task automatic runCommand(input int hold, input bit doAck);
        predictCommand();
        for (int i = 0; i <= expLast; i++) begin
            applyStimulus(cmdQ[i]);
            if (i == expLast && (expKind == K_BAD || expKind == K_NOTERM)) begin
                expErrCode = 3'(expKind);
                checkOutput("errPulse on reject", errPulse, 1);
                checkOutput("errCode on reject", errCode, expErrCode);
                checkOutput("busy after reject", busy, 0);
            end else begin
                checkOutput("errPulse in command", errPulse, 0);
                checkOutput("busy in command", busy, 1);
            end
            if (i == expLast && expKind == K_TIMEOUT) begin
                repeat (LIMIT - 1) tick();
                checkOutput("no early timeout", errPulse, 0);
                checkOutput("busy before timeout", busy, 1);
                tick();
                expErrCode = 3'd3;
                checkOutput("errPulse on timeout", errPulse, 1);
                checkOutput("errCode on timeout", errCode, expErrCode);
                checkOutput("busy after timeout", busy, 0);
            end else if (i < expLast && gapQ[i] > 0) begin
                repeat (gapQ[i]) tick();
                checkOutput("busy across gap", busy, 1);
            end
        end
        if (expKind == K_OK || expKind == K_RANGE) begin
            checkOutput("wrReq low in check", wrReq, 0);
            tick();
            if (expKind == K_RANGE) begin
                expErrCode = 3'd2;
                checkOutput("errPulse on range", errPulse, 1);
                checkOutput("errCode on range", errCode, expErrCode);
                checkOutput("wrReq on range", wrReq, 0);
                checkFields("range keeps fields");
            end else begin
                for (int k = 0; k < 7; k++) expSet[k] = predSet[k];
                checkOutput("wrReq raised", wrReq, 1);
                checkOutput("errPulse on accept", errPulse, 0);
                checkFields("accepted");
                foreach (junkQ[j]) begin
                    applyStimulus(junkQ[j]);
                    checkOutput("errPulse junk in req", errPulse, 0);
                    checkOutput("wrReq held by junk", wrReq, 1);
                end
                repeat (hold) tick();
                checkOutput("wrReq held", wrReq, 1);
                checkFields("held");
                if (doAck) ackRequest();
            end
        end
        tick();
        checkOutput("errPulse one cycle", errPulse, 0);
        checkOutput("errCode held", errCode, expErrCode);
    endtask

    function automatic logic [7:0] digitChar(input int v);
        return 8'(48 + v);
    endfunction

    task automatic buildRandom();
        int v [7];
        int b, r;
        cmdQ.delete();
        gapQ.delete();
        junkQ.delete();
        v[0] = $urandom_range(0, 99);
        v[1] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 99) : $urandom_range(1, 12);
        v[2] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 99) : $urandom_range(1, 31);
        v[3] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 23);
        v[4] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 59);
        v[5] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 59);
        v[6] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : $urandom_range(1, 7);
        cmdQ.push_back(8'h54);
        for (int k = 0; k < 6; k++) begin
            cmdQ.push_back(digitChar(v[k] / 10));
            cmdQ.push_back(digitChar(v[k] % 10));
        end
        cmdQ.push_back(digitChar(v[6]));
        if ($urandom_range(0, 9) == 0) begin
            b = $urandom_range(0, 245);
            if (b >= 48) b += 10;
            cmdQ[$urandom_range(1, 13)] = 8'(b);
        end
        r = $urandom_range(0, 9);
        if (r == 0) begin
            b = $urandom_range(0, 253);
            if (b >= 10) b++;
            if (b >= 13) b++;
            cmdQ.push_back(8'(b));
        end else begin
            cmdQ.push_back((r <= 5) ? 8'h0D : 8'h0A);
        end
        for (int i = 0; i < 15; i++) begin
            r = $urandom_range(0, 99);
            gapQ.push_back((r == 0) ? LIMIT : (r == 1) ? LIMIT - 1 : (r < 30) ? $urandom_range(1, 4) : 0);
        end
        r = $urandom_range(0, 3);
        for (int j = 0; j < r; j++) junkQ.push_back(8'($urandom));
    endtask

    task automatic idleGarbage(input int n);
        int b;
        for (int j = 0; j < n; j++) begin
            b = $urandom_range(0, 254);
            if (b >= 84) b++;
            applyStimulus(8'(b));
            checkOutput("errPulse idle garbage", errPulse, 0);
            checkOutput("busy idle garbage", busy, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst    = 1'b1;
        rxDone = 1'b0;
        rxData = 8'h00;
        wrAck  = 1'b0;
        for (int k = 0; k < 7; k++) expSet[k] = 8'h00;
        expErrCode = 3'd0;
        repeat (3) tick();
        rst = 1'b0;
        checkResetState("reset");

        loadCmd("T2405171234563", 1'b1, 8'h0D);
        runCommand(3, 1'b0);
        checkOutput("plan setYr", setYr, 8'h24);
        checkOutput("plan setMon", setMon, 8'h05);
        checkOutput("plan setDate", setDate, 8'h17);
        checkOutput("plan setHrs", setHrs, 8'h12);
        checkOutput("plan setMin", setMin, 8'h34);
        checkOutput("plan setSec", setSec, 8'h56);
        checkOutput("plan setDay", setDay, 8'h03);
        ackRequest();

        loadCmd("T2413171234563", 1'b1, 8'h0A);
        runCommand(0, 1'b1);
        checkOutput("plan month range code", errCode, 2);
        loadCmd("T2405172460003", 1'b1, 8'h0D);
        runCommand(0, 1'b1);
        checkOutput("plan hour range code", errCode, 2);

        loadCmd("T24A5171234563", 1'b1, 8'h0D);
        runCommand(0, 1'b1);
        checkOutput("plan bad char code", errCode, 1);
        loadCmd("T2012310000007", 1'b1, 8'h0A);
        runCommand(2, 1'b1);

        loadCmd("T24051712345637", 1'b0, 8'h00);
        runCommand(0, 1'b1);
        checkOutput("plan no terminator code", errCode, 4);

        loadCmd("T2405", 1'b0, 8'h00);
        gapQ[4] = LIMIT;
        runCommand(0, 1'b1);

        loadCmd("T2405171234563", 1'b1, 8'h0D);
        junkQ.delete();
        loadCmd("T9912312359597", 1'b1, 8'h0D);
        for (int j = 0; j < 15; j++) junkQ.push_back(cmdQ[j]);
        cmdQ.delete();
        for (int j = 0; j < 15; j++) cmdQ.push_back(junkQ[j]);
        junkQ.delete();
        loadCmd("T2405171234563", 1'b1, 8'h0D);
        begin
            string junkStr = "T9912312359597";
            for (int j = 0; j < junkStr.len(); j++) junkQ.push_back(junkStr[j]);
            junkQ.push_back(8'h0D);
        end
        runCommand(50, 1'b1);
        applyStimulus(8'h78);
        checkOutput("errPulse after x", errPulse, 0);
        applyStimulus(8'h35);
        checkOutput("errPulse after 5", errPulse, 0);
        checkOutput("busy after garbage", busy, 0);

        applyStimulus(8'h54);
        applyStimulus(8'h32);
        applyStimulus(8'h34);
        pulseReset("reset mid collect");
        loadCmd("T0101010000001", 1'b1, 8'h0D);
        runCommand(1, 1'b0);
        pulseReset("reset mid req");
        loadCmd("T2405171234563", 1'b1, 8'h0A);
        runCommand(1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            buildRandom();
            runCommand($urandom_range(0, 5), 1'b1);
            idleGarbage($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
